uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Scheduler placed in front of the UART transmitter (p_data/data_valid/busy interface). Shares the transmitter between two requesters: the ALU result path (multi-byte word) and the register-file read path (single byte). Serialises each request into byte frames, LSB byte first, pacing on the transmitter's busy. Round-robin arbitration when both requesters are pending.

Parameters:
DATA_WIDTH, 8, UART byte width; width of p_data and rf_data.
ALU_BYTES, 2, bytes per ALU result; alu_data width is ALU_BYTES*DATA_WIDTH.
BUSY_TIMEOUT, 4, cycles to wait in WAIT_HI for tx_busy to rise before re-issuing the byte.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
alu_req  in  1  ALU result pending; held high until alu_ack
alu_data  in  ALU_BYTES*DATA_WIDTH  ALU result; stable while alu_req=1
alu_ack  out  1  one-cycle pulse when the ALU word is captured
rf_req  in  1  register-file byte pending; held high until rf_ack
rf_data  in  DATA_WIDTH  register-file read data; stable while rf_req=1
rf_ack  out  1  one-cycle pulse when the RF byte is captured
p_data  out  DATA_WIDTH  byte to the UART transmitter
data_valid  out  1  one-cycle load strobe to the UART transmitter
tx_busy  in  1  UART transmitter busy
sched_busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky; set on any BUSY_TIMEOUT expiry; cleared only by rst

Behaviour:
- Reset (async, rst=1): state=IDLE; p_data=0, data_valid=0, alu_ack=0, rf_ack=0, sched_busy=0, timeout_err=0; last_grant=RF, so ALU wins the first tie.
- All outputs are registered.
- States:
  - IDLE: no action until a request is present.
  - SEND: data_valid=1 for exactly one cycle; p_data holds the current byte.
  - WAIT_HI: wait for tx_busy=1.
  - WAIT_LO: wait for tx_busy=0.
- IDLE, with tx_busy=0 and any request present at edge N:
  - Grant: if only one request, grant it. If both, grant the one not equal to last_grant.
  - Capture the data into the shift register; byte count = ALU_BYTES for ALU, 1 for RF.
  - Pulse the granted ack in cycle N+1 and update last_grant.
  - Enter SEND in cycle N+1 with data_valid=1 and p_data=byte0.
- IDLE with tx_busy=1: no grant; stay in IDLE.
- SEND -> WAIT_HI unconditionally; data_valid drops. p_data is held until the next SEND.
- WAIT_HI:
  - tx_busy=1 -> WAIT_LO, clear the timeout counter.
  - tx_busy still 0 after BUSY_TIMEOUT cycles -> SEND, re-issuing the same byte, and set timeout_err.
- WAIT_LO, tx_busy=0:
  - bytes remaining -> SEND with the next byte (shift right by DATA_WIDTH, decrement count).
  - last byte done -> IDLE.
- Back-to-back: a request pending at the cycle IDLE is re-entered is granted on the next edge. Minimum gap between frames is 1 idle cycle.
- A requester dropping req before ack is a protocol violation; behaviour is unspecified and the bench must not drive it.
- Acks never assert outside the cycle after an IDLE grant. alu_ack and rf_ack are never high together.
- Reset mid-transfer: the frame is abandoned and no further bytes are sent. An acked word is lost; a requester still holding req is re-arbitrated after reset.
- The byte counter is $clog2(ALU_BYTES+1) bits wide and never wraps; the timeout counter saturates.

Decomposition:
- Shared package: state encoding (IDLE, SEND, WAIT_HI, WAIT_LO), grant enum (GRANT_ALU, GRANT_RF), DATA_WIDTH default.
- One sub-module: uart_tx_rr_arb. Two-requester round-robin arbiter with a last_grant register and a grant_en input driven high only in IDLE.

Test Plan:
1. Reset dominance: rst=1 while alu_req=rf_req=1 for 50 cycles -> data_valid, alu_ack, rf_ack all 0; sched_busy=0.
2. Single RF request, rf_data=0xA5, transmitter model busy for 10 cycles starting one cycle after data_valid -> rf_ack and data_valid with p_data=0xA5 one cycle after the request is sampled; sched_busy falls 1 cycle after tx_busy falls.
3. Single ALU request, alu_data=0x1234 -> two frames, p_data=0x34 then 0x12. The second data_valid comes exactly 1 cycle after tx_busy falls. One alu_ack only.
4. Simultaneous alu_req and rf_req held high across 4 transfers -> grant order ALU, RF, ALU, RF; never both acks in the same cycle.
5. Transmitter model never raises busy -> data_valid re-pulses every BUSY_TIMEOUT+1 cycles with the same p_data; timeout_err sets and stays set.
6. rst pulsed during the second byte of an ALU transfer with rf_req pending -> no further data_valid until reset releases, then RF is granted.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types for the UART transmit scheduler: FSM state encoding and grant identity.
package uart_tx_sched_pkg;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_RF  = 1'b1
  } grant_t;
endpackage

// File: rtl/uart_tx_rr_arb.sv
// Two-requester round-robin arbiter; last_grant advances only when grant_en commits a grant.
module uart_tx_rr_arb
  import uart_tx_sched_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   grant_en,
  input  logic   alu_req,
  input  logic   rf_req,
  output logic   grant_valid,
  output grant_t grant
);
  grant_t last_grant;

  always_comb begin
    grant_valid = alu_req | rf_req;
    grant       = GRANT_ALU;
    if (alu_req && rf_req) begin
      grant = (last_grant == GRANT_ALU) ? GRANT_RF : GRANT_ALU;
    end else if (rf_req) begin
      grant = GRANT_RF;
    end
  end

  // Reset to RF so that the ALU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_RF;
    end else if (grant_en && grant_valid) begin
      last_grant <= grant;
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between the ALU word path and the register-file byte path,
// sending each request LSB byte first and pacing every byte on tx_busy.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ALU_BYTES    = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_req,
  input  logic [ALU_BYTES*DATA_WIDTH-1:0] alu_data,
  output logic                            alu_ack,
  input  logic                            rf_req,
  input  logic [DATA_WIDTH-1:0]           rf_data,
  output logic                            rf_ack,
  output logic [DATA_WIDTH-1:0]           p_data,
  output logic                            data_valid,
  input  logic                            tx_busy,
  output logic                            sched_busy,
  output logic                            timeout_err
);
  localparam int WORD_W = ALU_BYTES * DATA_WIDTH;
  localparam int CNT_W  = $clog2(ALU_BYTES + 1);
  localparam int TO_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_BYTES);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  byte_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              grant_en;
  logic              grant_valid;
  grant_t            grant;
  logic [WORD_W-1:0] cap_word;
  logic [WORD_W-1:0] next_word;

  // Grants are only committed from IDLE with the transmitter free.
  assign grant_en = (state == IDLE) && !tx_busy;

  uart_tx_rr_arb u_arb (
    .clk         (clk),
    .rst         (rst),
    .grant_en    (grant_en),
    .alu_req     (alu_req),
    .rf_req      (rf_req),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    cap_word = '0;
    if (grant == GRANT_ALU) begin
      cap_word = alu_data;
    end else begin
      cap_word[DATA_WIDTH-1:0] = rf_data;
    end
    next_word = shreg >> DATA_WIDTH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      p_data      <= '0;
      data_valid  <= 1'b0;
      alu_ack     <= 1'b0;
      rf_ack      <= 1'b0;
      sched_busy  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      alu_ack    <= 1'b0;
      rf_ack     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_en && grant_valid) begin
            shreg      <= cap_word;
            p_data     <= cap_word[DATA_WIDTH-1:0];
            byte_cnt   <= (grant == GRANT_ALU) ? ALU_CNT : ONE_CNT;
            alu_ack    <= (grant == GRANT_ALU);
            rf_ack     <= (grant == GRANT_RF);
            data_valid <= 1'b1;
            sched_busy <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          to_cnt <= '0;
          state  <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            to_cnt <= '0;
            state  <= WAIT_LO;
          end else if (to_cnt >= TO_LAST) begin
            // Transmitter never picked the byte up: strobe it again, p_data unchanged.
            to_cnt      <= '0;
            data_valid  <= 1'b1;
            timeout_err <= 1'b1;
            state       <= SEND;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (byte_cnt > ONE_CNT) begin
              shreg      <= next_word;
              p_data     <= next_word[DATA_WIDTH-1:0];
              byte_cnt   <= byte_cnt - ONE_CNT;
              data_valid <= 1'b1;
              state      <= SEND;
            end else begin
              byte_cnt   <= '0;
              sched_busy <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised scoreboard bench for uart_tx_sched with a behavioural transmitter and
// round-robin reference model.
module tb_uart_tx_sched;
  import uart_tx_sched_pkg::*;

  localparam int DW = 8;
  localparam int AB = 2;
  localparam int BT = 4;
  localparam int WW = AB * DW;
  localparam int BOUND = 3000;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          alu_req, rf_req, tx_busy;
  logic [WW-1:0] alu_data;
  logic [DW-1:0] rf_data;
  logic          alu_ack, rf_ack, data_valid, sched_busy, timeout_err;
  logic [DW-1:0] p_data;

  uart_tx_sched #(.DATA_WIDTH(DW), .ALU_BYTES(AB), .BUSY_TIMEOUT(BT)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_req     (alu_req),
    .alu_data    (alu_data),
    .alu_ack     (alu_ack),
    .rf_req      (rf_req),
    .rf_data     (rf_data),
    .rf_ack      (rf_ack),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .tx_busy     (tx_busy),
    .sched_busy  (sched_busy),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] exp_q[$];
  logic [WW-1:0] alu_words[$];
  logic [DW-1:0] rf_words[$];
  grant_t        grant_log[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Transmitter model: busy for busy_len cycles starting the cycle after each load strobe.
  int busy_len  = 10;
  bit tx_silent = 1'b0;
  int busy_left = 0;
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        busy_left = 0;
        tx_busy   = 1'b0;
      end else begin
        if (busy_left > 0) begin
          tx_busy = 1'b1;
          busy_left--;
        end else begin
          tx_busy = 1'b0;
        end
        if (data_valid && !tx_silent) busy_left = busy_len;
      end
    end
  end

  // Monitor / scoreboard
  bit            prev_alu_req = 1'b0, prev_rf_req = 1'b0, prev_busy = 1'b0;
  grant_t        model_last = GRANT_RF;
  bit            retry_armed = 1'b0, word_done = 1'b0, terr_exp = 1'b0;
  int            last_dv_cyc = 0, busy_fall_cyc = -100, idle_due = -1;
  logic [DW-1:0] last_byte = '0;
  int            dv_cnt = 0, alu_ack_cnt = 0;

  always @(negedge clk) begin
    grant_t        exp_g, got_g;
    logic [WW-1:0] w;
    logic [DW-1:0] e;
    int            nb;
    cyc++;
    if (rst) begin
      check("rst_data_valid", 32'(data_valid), 32'd0);
      check("rst_acks", 32'({alu_ack, rf_ack}), 32'd0);
      check("rst_sched_busy", 32'(sched_busy), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      check("rst_p_data", 32'(p_data), 32'd0);
      exp_q.delete();
      model_last  = GRANT_RF;
      retry_armed = 1'b0;
      word_done   = 1'b0;
      terr_exp    = 1'b0;
      idle_due    = -1;
    end else begin
      if (tx_busy) retry_armed = 1'b0;
      if (prev_busy && !tx_busy) begin
        busy_fall_cyc = cyc;
        if (word_done) begin
          idle_due  = cyc + 1;
          word_done = 1'b0;
        end
      end
      if (alu_ack || rf_ack) begin
        check("ack_onehot", 32'(alu_ack & rf_ack), 32'd0);
        check("ack_had_req", 32'(prev_alu_req | prev_rf_req), 32'd1);
        if (prev_alu_req && prev_rf_req) exp_g = (model_last == GRANT_ALU) ? GRANT_RF : GRANT_ALU;
        else if (prev_rf_req)            exp_g = GRANT_RF;
        else                             exp_g = GRANT_ALU;
        got_g = alu_ack ? GRANT_ALU : GRANT_RF;
        check("rr_grant", 32'(got_g), 32'(exp_g));
        model_last = exp_g;
        grant_log.push_back(got_g);
        if (alu_ack) alu_ack_cnt++;
        check("ack_with_valid", 32'(data_valid), 32'd1);
        check("ack_sched_busy", 32'(sched_busy), 32'd1);
        if (got_g == GRANT_ALU) begin
          check("alu_word_queued", 32'(alu_words.size() != 0), 32'd1);
          if (alu_words.size() != 0) begin
            w = alu_words.pop_front();
            for (int i = 0; i < AB; i++) exp_q.push_back(w[i*DW +: DW]);
          end
        end else begin
          check("rf_word_queued", 32'(rf_words.size() != 0), 32'd1);
          if (rf_words.size() != 0) exp_q.push_back(rf_words.pop_front());
        end
      end
      if (data_valid) begin
        dv_cnt++;
        if (retry_armed) begin
          check("retry_gap", 32'(cyc - last_dv_cyc), 32'(BT + 1));
          check("retry_byte", 32'(p_data), 32'(last_byte));
          terr_exp = 1'b1;
        end else begin
          check("dv_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("byte", 32'(p_data), 32'(e));
            if (exp_q.size() == 0) word_done = 1'b1;
          end
          if (!(alu_ack || rf_ack)) check("next_byte_gap", 32'(cyc - busy_fall_cyc), 32'd1);
        end
        retry_armed = 1'b1;
        last_dv_cyc = cyc;
        last_byte   = p_data;
      end
      if (idle_due == cyc) begin
        check("sched_busy_fall", 32'(sched_busy), 32'd0);
        idle_due = -1;
      end
      nb = 0;
      check("timeout_err", 32'(timeout_err), 32'(terr_exp));
    end
    prev_alu_req = alu_req;
    prev_rf_req  = rf_req;
    prev_busy    = tx_busy;
  end

  // Driver tasks
  task automatic alu_send(input logic [WW-1:0] w, input bit keep, output int lat);
    alu_words.push_back(w);
    alu_data = w;
    alu_req  = 1'b1;
    lat = 0;
    do begin @(posedge clk); #2; lat++; end while (!alu_ack && lat < BOUND);
    check("alu_ack_seen", 32'(alu_ack), 32'd1);
    if (!keep) alu_req = 1'b0;
  endtask

  task automatic rf_send(input logic [DW-1:0] w, input bit keep, output int lat);
    rf_words.push_back(w);
    rf_data = w;
    rf_req  = 1'b1;
    lat = 0;
    do begin @(posedge clk); #2; lat++; end while (!rf_ack && lat < BOUND);
    check("rf_ack_seen", 32'(rf_ack), 32'd1);
    if (!keep) rf_req = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(posedge clk); #2; t++; end
    while ((sched_busy || tx_busy || exp_q.size() != 0) && t < BOUND);
    check("idle_reached", 32'(t < BOUND), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    grant_log.delete();
  endtask

  // Main sequence
  initial begin
    int     lat_a, lat_r, a0, d0, t;
    grant_t exp_order[4];
    alu_req = 1'b0; rf_req = 1'b0; alu_data = '0; rf_data = '0;

    // Reset dominance with both requests high
    repeat (2) @(posedge clk);
    #2;
    alu_req = 1'b1; rf_req = 1'b1; alu_data = 16'hBEEF; rf_data = 8'h77;
    repeat (50) @(posedge clk);
    #2;
    alu_req = 1'b0; rf_req = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    // Single RF byte
    busy_len = 10;
    rf_send(8'hA5, 1'b0, lat_r);
    check("rf_ack_latency", 32'(lat_r), 32'd1);
    check("rf_first_p_data", 32'(p_data), 32'hA5);
    wait_idle();

    // Single ALU word, two frames
    a0 = alu_ack_cnt; d0 = dv_cnt;
    alu_send(16'h1234, 1'b0, lat_a);
    check("alu_ack_latency", 32'(lat_a), 32'd1);
    check("alu_first_p_data", 32'(p_data), 32'h34);
    wait_idle();
    check("alu_ack_count", 32'(alu_ack_cnt - a0), 32'd1);
    check("alu_frame_count", 32'(dv_cnt - d0), 32'd2);

    // Ties across four transfers
    pulse_reset();
    busy_len = 3;
    fork
      begin
        alu_send(WW'($urandom()), 1'b1, lat_a);
        alu_send(WW'($urandom()), 1'b0, lat_a);
      end
      begin
        rf_send(DW'($urandom()), 1'b1, lat_r);
        rf_send(DW'($urandom()), 1'b0, lat_r);
      end
    join
    wait_idle();
    exp_order = '{GRANT_ALU, GRANT_RF, GRANT_ALU, GRANT_RF};
    check("tie_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("tie_grant_order", 32'(grant_log[i]), 32'(exp_order[i]));

    // Transmitter never goes busy: re-issue on timeout
    pulse_reset();
    tx_silent = 1'b1;
    rf_send(8'h3C, 1'b0, lat_r);
    d0 = dv_cnt;
    repeat (22) @(posedge clk);
    #0;
    check("retry_pulse_count", 32'(dv_cnt - d0), 32'd5);
    check("timeout_err_sticky", 32'(timeout_err), 32'd1);
    check("retry_p_data_held", 32'(p_data), 32'h3C);
    tx_silent = 1'b0;
    pulse_reset();
    check("timeout_err_cleared", 32'(timeout_err), 32'd0);

    // Reset during the second ALU byte while RF waits
    busy_len = 6;
    d0 = dv_cnt;
    fork
      alu_send(16'hC3E1, 1'b0, lat_a);
      begin
        repeat (3) @(posedge clk);
        #2;
        rf_send(8'h5A, 1'b0, lat_r);
      end
      begin
        t = 0;
        while (dv_cnt < d0 + 2 && t < BOUND) begin @(posedge clk); #2; t++; end
        check("second_alu_byte_seen", 32'(t < BOUND), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
      end
    join
    wait_idle();
    check("post_reset_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() != 0) check("post_reset_rf_grant", 32'(grant_log[$]), 32'(GRANT_RF));

    // Randomised mixed traffic
    for (int it = 0; it < 24; it++) begin
      int kind;
      kind = $urandom_range(0, 2);
      busy_len = $urandom_range(1, 8);
      fork
        if (kind != 1) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          alu_send(WW'($urandom()), 1'b0, lat_a);
        end
        if (kind != 0) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          rf_send(DW'($urandom()), 1'b0, lat_r);
        end
      join
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #3_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
